a2d_sequencer: RTL

Round-robin conversion scheduler that owns the 16-bit SPI master (SPI_mstr16) in front of the ADC128S.
Each trigger converts one channel from a fixed list of three: left load cell, right load cell, battery.
Per channel, the block runs the two-transaction ADC protocol and latches the 12-bit result into a per-channel register.
It sits between the balance/steering control logic and the SPI master. It is the only writer of the master's cmd/wrt.

---
 rtl/a2d_pkg.sv | 33 +++
 rtl/a2d_auto_tmr.sv | 24 ++
 rtl/a2d_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types, channel map and command builder for the A2D round-robin sequencer.
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, CMD1, WAIT1, GAP, CMD2, WAIT2, STORE} state_t;
    typedef enum logic [1:0] {RB_LFT, RB_RGHT, RB_BATT} robin_t;

    localparam logic [2:0]  LFT_CH           = 3'd0;
    localparam logic [2:0]  RGHT_CH          = 3'd4;
    localparam logic [2:0]  BATT_CH          = 3'd5;
    localparam logic [19:0] AUTO_PERIOD_DFLT = 20'd1_000_000;
    localparam logic [10:0] CMD_PAD          = 11'h000;

    function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
        return {2'b00, ch, CMD_PAD};
    endfunction

    function automatic logic [2:0] rb_ch(input robin_t rb);
        case (rb)
            RB_RGHT: return RGHT_CH;
            RB_BATT: return BATT_CH;
            default: return LFT_CH;
        endcase
    endfunction

    function automatic robin_t rb_next(input robin_t rb);
        case (rb)
            RB_LFT:  return RB_RGHT;
            RB_RGHT: return RB_BATT;
            default: return RB_LFT;
        endcase
    endfunction

endpackage

// File: rtl/a2d_auto_tmr.sv
// Free-running period counter producing a one-cycle auto trigger at terminal count.
module a2d_auto_tmr
    import a2d_pkg::*;
#(
    parameter logic [19:0] AUTO_PERIOD = AUTO_PERIOD_DFLT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [19:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == 20'd0);
        cnt_d = tick ? (AUTO_PERIOD - 20'd1) : (cnt_q - 20'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= AUTO_PERIOD - 20'd1;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/a2d_sequencer.sv
// Round-robin ADC128S conversion scheduler driving the 16-bit SPI master.
// Build option: define A2D_AUTO_EN to add a periodic internal trigger.
module a2d_sequencer
    import a2d_pkg::*;
`ifdef A2D_AUTO_EN
#(
    parameter logic [19:0] AUTO_PERIOD = AUTO_PERIOD_DFLT
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic [15:0] spi_cmd,
    output logic        spi_wrt,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        cnv_cmplt
);

    state_t      state_q, state_d;
    robin_t      robin_q, robin_d;
    logic [15:0] cmd_q, cmd_d;
    logic [11:0] lft_q, lft_d, rght_q, rght_d, batt_q, batt_d;
    logic        busy_q, busy_d;
    logic        cnv_q, cnv_d;
    logic        trig;

    // The ADC only reports 12 bits; the top nibble is don't-care.
    logic unused_rd_hi;
    assign unused_rd_hi = ^spi_rd_data[15:12];

`ifdef A2D_AUTO_EN
    logic tick;
    a2d_auto_tmr #(.AUTO_PERIOD(AUTO_PERIOD)) u_auto_tmr (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );
    assign trig = nxt | tick;
`else
    assign trig = nxt;
`endif

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        robin_d = robin_q;
        cmd_d   = cmd_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        busy_d  = busy_q;
        cnv_d   = 1'b0;
        spi_wrt = 1'b0;

        case (state_q)
            IDLE: if (trig) begin
                state_d = CMD1;
                busy_d  = 1'b1;
                cmd_d   = mk_cmd(rb_ch(robin_q));
            end
            CMD1: begin
                spi_wrt = 1'b1;
                state_d = WAIT1;
            end
            WAIT1: if (spi_done) state_d = GAP;
            GAP:   state_d = CMD2;
            CMD2: begin
                spi_wrt = 1'b1;
                state_d = WAIT2;
            end
            WAIT2: if (spi_done) state_d = STORE;
            STORE: begin
                // Second reply carries this channel's sample; the first was stale.
                case (robin_q)
                    RB_RGHT: rght_d = spi_rd_data[11:0];
                    RB_BATT: batt_d = spi_rd_data[11:0];
                    default: lft_d  = spi_rd_data[11:0];
                endcase
                cnv_d   = 1'b1;
                busy_d  = 1'b0;
                robin_d = rb_next(robin_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            robin_q <= RB_LFT;
            cmd_q   <= 16'h0000;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'h000;
            busy_q  <= 1'b0;
            cnv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            robin_q <= robin_d;
            cmd_q   <= cmd_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
            busy_q  <= busy_d;
            cnv_q   <= cnv_d;
        end
    end

    assign spi_cmd   = cmd_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign busy      = busy_q;
    assign cnv_cmplt = cnv_q;

endmodule
